filter_phase_block_watchdog: RTL and testbench
==============================================

# filter_phase_block_watchdog

Recovery sequencer for the filter_phase HLS core. It consumes the core's AXIS deadlock-monitor outputs (`block`, `axis_block_info`). When a stall persists, it holds the upstream stream, pulses a soft reset into the core, drains, and re-arms. Repeated failures escalate to a latched fault. It sits between the deadlock monitor and the filter_phase core's reset/stream-gating logic and exposes status to the control register bank.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: consecutive `block` samples that declare a stall. Also the clean-run length that clears retries. Must be ≥2.
- `RESET_CYCLES`, default 16: width of the `core_rst` pulse. Must be ≥1.
- `DRAIN_CYCLES`, default 64: post-reset hold time before re-arming. Must be ≥1.
- `MAX_RETRIES`, default 3: recoveries allowed before FAULT. Must be ≥1.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: arms the watchdog.
- `block` in 1: stall flag from the deadlock monitor.
- `axis_block_info` in 4: per-channel stall code from the deadlock monitor.
- `clear_fault` in 1: single-cycle pulse that releases FAULT.
- `core_rst` out 1: soft reset to the filter_phase core.
- `in_hold` out 1: gates upstream tvalid into the core.
- `fault` out 1: latched escalation flag.
- `state` out 3: current state code.
- `recover_count` out 8: total recoveries, saturating at 255.
- `last_info` out 4: `axis_block_info` captured at the most recent stall declaration.

## Operation
- States and codes: IDLE=0, ARMED=1, WATCH=2, RECOVER=3, DRAIN=4, FAULT=5.
- All outputs are registered and decoded from the state register and counters.
- IDLE: go to ARMED when `enable`=1.
- ARMED:
  - `enable`=0 → IDLE.
  - `block`=1 → WATCH; cnt←1.
  - Otherwise clean_cnt++. When clean_cnt reaches `TIMEOUT_CYCLES`, retry_cnt←0. clean_cnt is cleared on leaving ARMED.
- WATCH:
  - `enable`=0 → IDLE.
  - `block`=0 → ARMED.
  - `block`=1 and cnt=`TIMEOUT_CYCLES`-1: this is the stall declaration. Capture `last_info`←`axis_block_info`.
    - If retry_cnt<`MAX_RETRIES`: → RECOVER; retry_cnt++; `recover_count`++ (saturating).
    - Otherwise → FAULT; `recover_count` is unchanged.
  - Otherwise cnt++.
- RECOVER:
  - `core_rst`=1, `in_hold`=1.
  - After `RESET_CYCLES` cycles → DRAIN.
  - `enable` and `block` are ignored.
- DRAIN:
  - `core_rst`=0, `in_hold`=1.
  - After `DRAIN_CYCLES` cycles: → ARMED if `enable`=1, else IDLE.
  - `block` is ignored.
- FAULT:
  - `core_rst`=1, `in_hold`=1, `fault`=1.
  - `clear_fault`=1 → DRAIN; retry_cnt←0; `fault`←0.
  - `enable` is ignored.
- Simultaneous events:
  - `enable` deassertion during RECOVER or DRAIN never truncates the sequence.
  - In WATCH, `enable`=0 takes priority over a timeout on the same edge.
- `state`, `last_info` and `recover_count` are readable at all times.

## Timing
- Reset values:
  - State IDLE; `state`=0.
  - `core_rst`=0, `in_hold`=0, `fault`=0.
  - `recover_count`=0, `last_info`=0.
  - All internal counters 0.
- Reset asserted mid-sequence (including RECOVER and FAULT) forces the reset values at the next edge.
- Stall declaration: `block` must be sampled high on `TIMEOUT_CYCLES` consecutive rising edges, starting with the ARMED edge. `core_rst` and `in_hold` rise in the cycle after the last of those edges.
- A single low sample of `block` in WATCH restarts the count.
- `core_rst` is high for exactly `RESET_CYCLES` cycles.
- `in_hold` is high for exactly `RESET_CYCLES`+`DRAIN_CYCLES` cycles per recovery.
- `in_hold` and `core_rst` are high continuously from FAULT entry. `core_rst` falls one cycle after `clear_fault` is sampled. `in_hold` falls `DRAIN_CYCLES` cycles later.
- `last_info` updates in the same cycle the state leaves WATCH on a stall declaration.
- retry_cnt clears only after `TIMEOUT_CYCLES` clean ARMED cycles. A restall inside that window counts toward `MAX_RETRIES`.

## Test plan
Test parameters: `TIMEOUT_CYCLES`=8, `RESET_CYCLES`=4, `DRAIN_CYCLES`=6, `MAX_RETRIES`=2.

1. **Glitch rejection.** `enable`=1; `block` high 7 cycles, low 1, high 7. Required: never leaves ARMED/WATCH; `core_rst`=0; `recover_count`=0.
2. **Single recovery.** `block` high for 8 edges with `axis_block_info`=4'hD. Required: `core_rst` high 4 cycles; `in_hold` high 10 cycles; `last_info`=4'hD; `recover_count`=1; state returns to 1.
3. **Escalation.** Stall repeatedly with no 8-cycle clean window. Required: recoveries 1 and 2 complete; the third declaration enters FAULT (`state`=5, `fault`=1, `core_rst`=1); `recover_count`=2. Then `clear_fault` pulse → `core_rst` falls next cycle, DRAIN 6 cycles, ARMED.
4. **Retry clearing.** Recover once, hold `block` low for 8 cycles, then stall twice more. Required: both stalls recover; no FAULT; `recover_count`=3.
5. **Enable drop mid-RECOVER.** Drop `enable` mid-RECOVER. Required: full 4+6 sequence completes, then IDLE. Separately, drop `enable` in WATCH on the timeout edge → IDLE with no reset pulse.
6. **Reset mid-sequence.** Assert `reset` mid-RECOVER and separately during FAULT. Required: next cycle all outputs 0, `state`=0; `last_info` and `recover_count` are cleared.

Source files
------------

// File: rtl/filter_phase_block_watchdog.sv
// Recovery sequencer for the filter_phase core: watches the deadlock monitor and resets/drains the core on a stall.
// Latency: outputs are registered; core_rst/in_hold rise the cycle after the TIMEOUT_CYCLES-th consecutive block sample.
// Backpressure: in_hold gates upstream tvalid for the whole reset+drain window and while faulted.
module filter_phase_block_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESET_CYCLES   = 16,
    parameter int DRAIN_CYCLES   = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       block,
    input  logic [3:0] axis_block_info,
    input  logic       clear_fault,
    output logic       core_rst,
    output logic       in_hold,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] recover_count,
    output logic [3:0] last_info
);

    // One shared phase counter serves WATCH, RECOVER and DRAIN, so size it for the largest.
    localparam int MAX_TR = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int MAXC   = (MAX_TR > DRAIN_CYCLES) ? MAX_TR : DRAIN_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int RW     = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] T_FULL = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] R_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_WATCH   = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] clean_q, clean_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    rc_q, rc_d;
    logic [3:0]    info_q, info_d;
    logic          core_rst_q, core_rst_d;
    logic          in_hold_q, in_hold_d;
    logic          fault_q, fault_d;

    // Next-state, counters and status capture; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        retry_d = retry_q;
        rc_d    = rc_q;
        info_d  = info_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                    clean_d = '0;
                end
            end
            S_ARMED: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    clean_d = '0;
                end else if (block) begin
                    // The ARMED edge is the first of the consecutive block samples.
                    state_d = S_WATCH;
                    cnt_d   = CW'(1);
                    clean_d = '0;
                end else begin
                    if (clean_q != T_FULL) begin
                        clean_d = clean_q + CW'(1);
                    end
                    if (clean_q >= T_LAST) begin
                        retry_d = '0;
                    end
                end
            end
            S_WATCH: begin
                // enable drop wins over a timeout on the same edge.
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!block) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                    clean_d = '0;
                end else if (cnt_q == T_LAST) begin
                    info_d = axis_block_info;
                    cnt_d  = '0;
                    if (retry_q < R_MAX) begin
                        state_d = S_RECOVER;
                        retry_d = retry_q + RW'(1);
                        if (rc_q != 8'hFF) begin
                            rc_d = rc_q + 8'd1;
                        end
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RECOVER: begin
                if (cnt_q == R_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == D_LAST) begin
                    state_d = enable ? S_ARMED : S_IDLE;
                    cnt_d   = '0;
                    clean_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        core_rst_d = (state_d == S_RECOVER) || (state_d == S_FAULT);
        in_hold_d  = (state_d == S_RECOVER) || (state_d == S_DRAIN) || (state_d == S_FAULT);
        fault_d    = (state_d == S_FAULT);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clean_q    <= '0;
            retry_q    <= '0;
            rc_q       <= '0;
            info_q     <= '0;
            core_rst_q <= 1'b0;
            in_hold_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clean_q    <= clean_d;
            retry_q    <= retry_d;
            rc_q       <= rc_d;
            info_q     <= info_d;
            core_rst_q <= core_rst_d;
            in_hold_q  <= in_hold_d;
            fault_q    <= fault_d;
        end
    end

    assign state         = state_q;
    assign core_rst      = core_rst_q;
    assign in_hold       = in_hold_q;
    assign fault         = fault_q;
    assign recover_count = rc_q;
    assign last_info     = info_q;

endmodule

// File: tb/tb_filter_phase_block_watchdog.sv
// Bench for filter_phase_block_watchdog: directed scenarios plus random stimulus.
// A streak/countdown reference model predicts every output each cycle.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_filter_phase_block_watchdog;

    localparam int T = 8;
    localparam int R = 4;
    localparam int D = 6;
    localparam int M = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       blk  = 1'b0;
    logic       clr  = 1'b0;
    logic [3:0] info = 4'h0;
    logic       o_core_rst, o_in_hold, o_fault;
    logic [2:0] o_state;
    logic [7:0] o_rc;
    logic [3:0] o_li;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    filter_phase_block_watchdog #(
        .TIMEOUT_CYCLES(T),
        .RESET_CYCLES  (R),
        .DRAIN_CYCLES  (D),
        .MAX_RETRIES   (M)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .enable         (en),
        .block          (blk),
        .axis_block_info(info),
        .clear_fault    (clr),
        .core_rst       (o_core_rst),
        .in_hold        (o_in_hold),
        .fault          (o_fault),
        .state          (o_state),
        .recover_count  (o_rc),
        .last_info      (o_li)
    );

    // Reference model: mode 0 idle, 1 armed, 2 watch, 5 fault, 6 = reset+drain hold
    // tracked as a countdown of remaining hold cycles.
    int m_mode = 0, m_streak = 0, m_clean = 0, m_retries = 0, m_left = 0, m_rc = 0, m_li = 0;
    int nx_mode, nx_streak, nx_clean, nx_retries, nx_left, nx_rc, nx_li;

    always_comb begin
        nx_mode    = m_mode;
        nx_streak  = m_streak;
        nx_clean   = m_clean;
        nx_retries = m_retries;
        nx_left    = m_left;
        nx_rc      = m_rc;
        nx_li      = m_li;
        if (rst) begin
            nx_mode = 0; nx_streak = 0; nx_clean = 0; nx_retries = 0;
            nx_left = 0; nx_rc = 0; nx_li = 0;
        end else begin
            case (m_mode)
                0: if (en) begin nx_mode = 1; nx_clean = 0; end
                1: begin
                    if (!en) nx_mode = 0;
                    else if (blk) begin nx_mode = 2; nx_streak = 1; end
                    else begin
                        nx_clean = m_clean + 1;
                        if (nx_clean >= T) nx_retries = 0;
                    end
                end
                2: begin
                    if (!en) nx_mode = 0;
                    else if (!blk) begin nx_mode = 1; nx_clean = 0; end
                    else begin
                        nx_streak = m_streak + 1;
                        if (nx_streak == T) begin
                            nx_li = int'(info);
                            if (m_retries < M) begin
                                nx_retries = m_retries + 1;
                                nx_rc      = (m_rc < 255) ? m_rc + 1 : 255;
                                nx_mode    = 6;
                                nx_left    = R + D;
                            end else begin
                                nx_mode = 5;
                            end
                        end
                    end
                end
                6: begin
                    if (m_left == 1) begin nx_mode = en ? 1 : 0; nx_clean = 0; end
                    else nx_left = m_left - 1;
                end
                5: if (clr) begin nx_retries = 0; nx_mode = 6; nx_left = D; end
                default: nx_mode = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        m_mode    <= nx_mode;
        m_streak  <= nx_streak;
        m_clean   <= nx_clean;
        m_retries <= nx_retries;
        m_left    <= nx_left;
        m_rc      <= nx_rc;
        m_li      <= nx_li;
    end

    function automatic int exp_state();
        if (m_mode == 6) return (m_left > D) ? 3 : 4;
        return m_mode;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_state", int'(o_state), exp_state());
            chk("cyc_core_rst", int'(o_core_rst), (exp_state() == 3 || exp_state() == 5) ? 1 : 0);
            chk("cyc_in_hold", int'(o_in_hold), (exp_state() >= 3) ? 1 : 0);
            chk("cyc_fault", int'(o_fault), (exp_state() == 5) ? 1 : 0);
            chk("cyc_recover_count", int'(o_rc), m_rc);
            chk("cyc_last_info", int'(o_li), m_li);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        cmp_on = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic go_armed();
        en = 1'b1;
        tick();
        chk("armed_entry", int'(o_state), 1);
    endtask

    task automatic wait_state(input int code, input int bound, input string name);
        int n = 0;
        while (int'(o_state) != code && n < bound) begin
            tick();
            n++;
        end
        chk(name, int'(o_state), code);
    endtask

    initial begin
        int cr, ih, bad, n;

        // Reset state
        do_reset();
        chk("rst_state", int'(o_state), 0);
        chk("rst_core_rst", int'(o_core_rst), 0);
        chk("rst_in_hold", int'(o_in_hold), 0);
        chk("rst_fault", int'(o_fault), 0);
        chk("rst_rc", int'(o_rc), 0);
        chk("rst_li", int'(o_li), 0);

        // 1: glitch rejection
        go_armed();
        bad = 0;
        blk = 1'b1;
        for (int i = 0; i < 15; i++) begin
            blk = (i == 7) ? 1'b0 : 1'b1;
            tick();
            if (o_state > 3'd2 || o_core_rst) bad++;
        end
        blk = 1'b0;
        tick();
        chk("glitch_no_recover", bad, 0);
        chk("glitch_rc", int'(o_rc), 0);
        chk("glitch_state", int'(o_state), 1);

        // 2: single recovery
        info = 4'hD;
        blk  = 1'b1;
        repeat (T) tick();
        chk("single_enter_recover", int'(o_state), 3);
        blk = 1'b0;
        info = 4'h0;
        cr = 0; ih = 0;
        for (int i = 0; i < 20; i++) begin
            cr += int'(o_core_rst);
            ih += int'(o_in_hold);
            tick();
        end
        chk("single_core_rst_cycles", cr, 4);
        chk("single_in_hold_cycles", ih, 10);
        chk("single_last_info", int'(o_li), 13);
        chk("single_rc", int'(o_rc), 1);
        chk("single_back_armed", int'(o_state), 1);

        // 3: escalation
        do_reset();
        go_armed();
        info = 4'h5;
        blk  = 1'b1;
        wait_state(5, 100, "esc_wait_fault");
        chk("esc_fault", int'(o_fault), 1);
        chk("esc_core_rst", int'(o_core_rst), 1);
        chk("esc_rc", int'(o_rc), 2);
        blk = 1'b0;
        repeat (3) tick();
        chk("esc_fault_sticky", int'(o_state), 5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("esc_clear_core_rst", int'(o_core_rst), 0);
        chk("esc_clear_drain", int'(o_state), 4);
        ih = 0;
        for (int i = 0; i < 10; i++) begin
            ih += int'(o_in_hold);
            tick();
        end
        chk("esc_drain_cycles", ih, 6);
        chk("esc_rearmed", int'(o_state), 1);

        // 4: retry clearing after a clean window
        do_reset();
        go_armed();
        blk = 1'b1;
        repeat (T) tick();
        blk = 1'b0;
        wait_state(1, 20, "retry_wait_armed");
        repeat (T) tick();
        blk = 1'b1;
        bad = 0; n = 0;
        while (!(o_rc == 8'd3 && o_state == 3'd3) && n < 100) begin
            tick();
            n++;
            if (o_fault) bad++;
        end
        chk("retry_reached_3", int'(o_rc), 3);
        blk = 1'b0;
        wait_state(1, 20, "retry_back_armed");
        chk("retry_no_fault", bad, 0);

        // 5a: enable drop mid-RECOVER
        do_reset();
        go_armed();
        blk = 1'b1;
        repeat (T) tick();
        blk = 1'b0;
        ih = 0;
        for (int i = 0; i < 20; i++) begin
            ih += int'(o_in_hold);
            if (i == 1) en = 1'b0;
            tick();
        end
        chk("endrop_hold_cycles", ih, 10);
        chk("endrop_idle", int'(o_state), 0);
        // 5b: enable drop on the timeout edge
        go_armed();
        blk = 1'b1;
        repeat (T - 1) tick();
        en = 1'b0;
        tick();
        blk = 1'b0;
        chk("watch_drop_idle", int'(o_state), 0);
        chk("watch_drop_no_rst", int'(o_core_rst), 0);
        chk("watch_drop_rc", int'(o_rc), 1);

        // 6: reset mid-RECOVER and during FAULT
        do_reset();
        go_armed();
        info = 4'hA;
        blk = 1'b1;
        repeat (T + 2) tick();
        blk = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rec_state", int'(o_state), 0);
        chk("rst_rec_core_rst", int'(o_core_rst), 0);
        chk("rst_rec_in_hold", int'(o_in_hold), 0);
        chk("rst_rec_rc", int'(o_rc), 0);
        chk("rst_rec_li", int'(o_li), 0);
        tick();
        blk = 1'b1;
        wait_state(5, 100, "rst_wait_fault");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        blk = 1'b0;
        chk("rst_flt_state", int'(o_state), 0);
        chk("rst_flt_fault", int'(o_fault), 0);
        chk("rst_flt_core_rst", int'(o_core_rst), 0);
        chk("rst_flt_rc", int'(o_rc), 0);
        chk("rst_flt_li", int'(o_li), 0);

        // Random phase: bursty block, rare enable drops, clear pulses and resets.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 11) == 0) blk = ~blk;
            en   = ($urandom_range(0, 99) < 97);
            clr  = ($urandom_range(0, 29) == 0);
            rst  = ($urandom_range(0, 999) < 2);
            info = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
